muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand and result width; only W=32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port flush  input  1  abort in-flight operation; pipeline kill.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV32M).
REQ-008 SHALL have port req_a  input  W  rs1 operand.
REQ-009 SHALL have port req_b  input  W  rs2 operand.
REQ-010 SHALL have port resp_valid  output  1  result available.
REQ-011 SHALL have port resp_ready  input  1  consumer takes result.
REQ-012 SHALL have port resp_data  output  W  result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL assert req_ready only in IDLE; acceptance is req_valid & req_ready at a rising edge.
REQ-016 SHALL capture op and operand magnitudes on acceptance; a signed operand is negated when its bit 31 is set, and the result-sign flag is recorded.
REQ-017 SHALL go IDLE->CALC on acceptance and run exactly 32 iterations, using one add/sub plus a 1-bit shift per cycle.
REQ-018 SHALL perform shift-add on a 64-bit product register for multiplication.
REQ-019 SHALL perform restoring division for division: the quotient bit is 1 when partial remainder >= divisor.
REQ-020 SHALL go CALC->FIX after the 32nd iteration; FIX applies sign correction and selects the low/high word, quotient or remainder; FIX->DONE.
REQ-021 SHALL hold resp_valid high only in DONE, with resp_data stable until resp_ready; DONE->IDLE on resp_valid & resp_ready.
REQ-022 SHALL have normal latency: resp_valid rises 34 cycles after the accept edge.
REQ-023 SHALL, for divide-by-zero (req_b==0), skip CALC and go IDLE->DONE: quotient 0xFFFFFFFF, remainder = req_a; resp_valid rises 1 cycle after accept.
REQ-024 SHALL, for signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF), skip CALC: quotient 0x80000000, remainder 0.
REQ-025 SHALL apply remainder sign = dividend sign and quotient sign = XOR of operand signs; a product is negated if the sign flag is set (MULHSU: only a is signed).
REQ-026 SHALL, on flush in any state, go to IDLE next edge with resp_valid low; flush has priority over acceptance and over resp handshake in the same cycle.
REQ-027 SHALL keep the iteration counter 6 bits wide; the counter SHALL not wrap and SHALL clear on entry to CALC.
REQ-028 SHALL ignore req_valid while not in IDLE; request inputs are don't-care then.

Reset
REQ-029 SHALL, on rst asserted, asynchronously force state IDLE, counter 0, and all datapath registers 0.
REQ-030 SHALL hold outputs during reset at req_ready=1, resp_valid=0, busy=0, resp_data=0.
REQ-031 SHALL, on reset mid-operation, discard the operation with no response ever issued.

Structure
REQ-032 SHALL place op encodings, state enum, and the overflow/div-zero constants in shared package muldiv_pkg.
REQ-033 SHALL place one iteration (conditional add/sub, compare, shift) in combinational sub-module muldiv_step; the FSM and registers stay in muldiv_seq.
REQ-034 SHALL use no multiplier or divider operators; only add/sub, compare, and shift.

Verification
REQ-035 SHALL cover: MUL a=7, b=-3 -> resp_data 0xFFFFFFEB after 34 cycles; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-037 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each 1 cycle after accept; DIV 0x80000000/-1 -> 0x80000000.
REQ-038 SHALL cover: resp_ready held low 10 cycles in DONE -> resp_data stable and req_ready low throughout; accept next request the cycle after the handshake.
REQ-039 SHALL cover: flush at CALC iteration 10 -> IDLE next cycle, no resp_valid; new request with flush same cycle -> not accepted.
REQ-040 SHALL cover: rst pulse mid-CALC -> outputs at reset values immediately (asynchronously), no stale response afterward.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and special-case constants for the sequential RV32M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
   localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;
   localparam logic [31:0] OVF_REM      = 32'h0000_0000;
   localparam logic [5:0]  LAST_ITER    = 6'd31;

   function automatic logic is_div(input op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_rem(input op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic a_signed(input op_e op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_signed(input op_e op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration on the 2W-bit accumulator.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           i_div,
   input  logic [2*W-1:0] i_acc,
   input  logic [W-1:0]   i_opnd,
   output logic [2*W-1:0] o_acc
);

   logic [W:0] w_sum;
   logic [W:0] w_rem;
   logic [W:0] w_diff;
   logic       w_ge;

   // Multiply: {hi,lo} with multiplier in lo; add multiplicand on lo[0], shift right.
   assign w_sum  = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_opnd} : '0);

   // Divide: {rem,quot} shifted left; partial remainder includes the bit shifted in.
   assign w_rem  = i_acc[2*W-1:W-1];
   assign w_ge   = (w_rem >= {1'b0, i_opnd});
   assign w_diff = w_rem - {1'b0, i_opnd};

   always_comb begin
      o_acc = '0;
      if (i_div) begin
         if (w_ge) o_acc = {w_diff[W-1:0], i_acc[W-2:0], 1'b1};
         else      o_acc = {i_acc[2*W-2:0], 1'b0};
      end else begin
         o_acc = {w_sum, i_acc[W-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide: 32 single-bit iterations, then a sign-fix cycle.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [W-1:0] resp_data,
   output logic         busy
);

   state_e         r_state, w_next;
   op_e            r_op;
   logic           r_neg_q, r_neg_r;
   logic [2*W-1:0] r_acc;
   logic [W-1:0]   r_opnd;
   logic [W-1:0]   r_result;
   logic [5:0]     r_cnt;

   op_e            w_op;
   logic           w_accept;
   logic           w_a_neg, w_b_neg;
   logic [W-1:0]   w_a_mag, w_b_mag;
   logic           w_div0, w_ovf, w_skip;
   logic [W-1:0]   w_special;
   logic [2*W-1:0] w_step_acc;
   logic [2*W-1:0] w_prod;
   logic [W-1:0]   w_quot, w_rem;
   logic [W-1:0]   w_fix_res;

   assign w_op     = op_e'(req_op);
   assign w_accept = req_valid & (r_state == S_IDLE) & ~flush;

   assign w_a_neg  = a_signed(w_op) & req_a[W-1];
   assign w_b_neg  = b_signed(w_op) & req_b[W-1];
   assign w_a_mag  = w_a_neg ? (~req_a + 1'b1) : req_a;
   assign w_b_mag  = w_b_neg ? (~req_b + 1'b1) : req_b;

   // Divide-by-zero and signed overflow have fixed RV32M results and bypass the iterations.
   assign w_div0   = is_div(w_op) & (req_b == '0);
   assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) &
                     (req_a == OVF_DIVIDEND) & (req_b == OVF_DIVISOR);
   assign w_skip   = w_div0 | w_ovf;

   always_comb begin
      w_special = '0;
      if (w_div0) w_special = is_rem(w_op) ? req_a : DIV0_QUOT;
      else        w_special = is_rem(w_op) ? OVF_REM : OVF_QUOT;
   end

   muldiv_step #(.W(W)) u_step (
      .i_div  (is_div(r_op)),
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .o_acc  (w_step_acc)
   );

   assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
   assign w_quot = r_neg_q ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
   assign w_rem  = r_neg_r ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];

   always_comb begin
      w_fix_res = '0;
      case (r_op)
         OP_MUL:                        w_fix_res = w_prod[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*W-1:W];
         OP_DIV, OP_DIVU:               w_fix_res = w_quot;
         default:                       w_fix_res = w_rem;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b1;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) w_next = w_skip ? S_DONE : S_CALC;
         end
         S_CALC:  if (r_cnt == LAST_ITER) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op     <= OP_MUL;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_result <= '0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_op    <= w_op;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_cnt   <= '0;
         if (w_skip) r_result <= w_special;
         if (is_div(w_op)) begin
            r_acc  <= {{W{1'b0}}, w_a_mag};
            r_opnd <= w_b_mag;
         end else begin
            r_acc  <= {{W{1'b0}}, w_b_mag};
            r_opnd <= w_a_mag;
         end
      end else if (!flush && r_state == S_CALC) begin
         r_acc <= w_step_acc;
         r_cnt <= r_cnt + 6'd1;
      end else if (!flush && r_state == S_FIX) begin
         r_result <= w_fix_res;
      end
   end

   assign resp_data = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector bench for muldiv_seq: results, latency, stall, flush and reset corners.
module tb_muldiv_seq;

   logic        clk, rst, flush;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   muldiv_seq #(.W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request, wait (bounded) for the response, then complete the handshake.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output int lat);
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      data = resp_data;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int          lat;
      logic        seen;

      vecs[0]  = '{"mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{"mulhu_max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      vecs[2]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
      vecs[3]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
      vecs[4]  = '{"divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14,        34};
      vecs[5]  = '{"remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         34};
      vecs[6]  = '{"divu_5_0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
      vecs[7]  = '{"rem_5_0",       3'd6, 32'd5,          32'd0,         32'd5,         1};
      vecs[8]  = '{"div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[9]  = '{"rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
      vecs[10] = '{"mulh_min_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
      vecs[11] = '{"mulhsu_m1_max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
      vecs[12] = '{"mulh_m2_3",     3'd1, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 34};
      vecs[13] = '{"mul_shift",     3'd0, 32'h1234_5678,  32'h10,        32'h2345_6780, 34};
      vecs[14] = '{"rem_m8_m3",     3'd6, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'hFFFF_FFFE, 34};
      vecs[15] = '{"divu_min_max",  3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};

      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      req_op = 3'd0; req_a = '0; req_b = '0;
      #12;
      chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_busy",       {31'd0, busy},       32'd0);
      chk("rst_resp_data",  resp_data,           32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, d, lat);
         chk({vecs[i].name, "_data"}, d, vecs[i].exp);
         chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      end

      // Response held off for 10 cycles, then a request queued behind the handshake.
      @(negedge clk);
      req_op = 3'd0; req_a = 32'd7; req_b = 32'hFFFF_FFFD; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("stall_lat", lat, 34);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_data",      resp_data,           32'hFFFF_FFEB);
         chk("stall_valid",     {31'd0, resp_valid}, 32'd1);
         chk("stall_req_ready", {31'd0, req_ready},  32'd0);
      end
      resp_ready = 1'b1;
      req_op = 3'd5; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
      chk("post_hs_busy",      {31'd0, busy},      32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("next_accept_busy", {31'd0, busy}, 32'd1);
      lat = 1;
      while (!resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("next_data", resp_data, 32'd14);
      chk("next_lat", lat, 34);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;

      // Flush around iteration 10 with a competing request, then again while idle.
      @(negedge clk);
      req_op = 3'd5; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1; req_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_busy",       {31'd0, busy},       32'd0);
      chk("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("flush_idle_no_accept", {31'd0, busy}, 32'd0);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      chk("flush_no_resp", {31'd0, seen}, 32'd0);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      req_op = 3'd3; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_req_ready",  {31'd0, req_ready},  32'd1);
      chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("arst_busy",       {31'd0, busy},       32'd0);
      chk("arst_resp_data",  resp_data,           32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      chk("arst_no_resp", {31'd0, seen}, 32'd0);

      run_op(3'd7, 32'd100, 32'd7, d, lat);
      chk("after_rst_data", d, 32'd2);
      chk("after_rst_lat", lat, 34);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
